// File: rtl/x_alp_exit_ctrl.sv
// Multi-channel exit controller: aggregates NUM_CH exit sources under a first/all
// completion policy with a watchdog, and presents one sticky registered exit event.
//   state | meaning
//   RUN   | collecting channel exits, watchdog counting
//   DONE  | exit event latched, all outputs and done mask frozen until clear_i
module x_alp_exit_ctrl #(
  parameter int                NUM_CH       = 4,
  parameter int                DATA_W       = 32,
  parameter int                ALL_MODE     = 0,
  parameter int                TIMEOUT_W    = 32,
  parameter logic [DATA_W-1:0] TIMEOUT_CODE = '1,
  localparam int               CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        ch_exit_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_exit_value_i,
  input  logic [TIMEOUT_W-1:0]     timeout_cycles_i,
  input  logic                     clear_i,
  output logic                     exit_valid_o,
  output logic [DATA_W-1:0]        exit_value_o,
  output logic [CH_W-1:0]          exit_ch_o,
  output logic                     exit_timeout_o,
  output logic [NUM_CH-1:0]        done_mask_o
);

  typedef enum logic {RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   done_mask_q, done_mask_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   cap_q [NUM_CH];
  logic [DATA_W-1:0]   cap_d [NUM_CH];
  logic                exit_valid_q, exit_valid_d;
  logic [DATA_W-1:0]   exit_value_q, exit_value_d;
  logic [CH_W-1:0]     exit_ch_q, exit_ch_d;
  logic                exit_timeout_q, exit_timeout_d;

  logic [NUM_CH-1:0]    new_mask;
  logic [NUM_CH-1:0]    mask_nxt;
  logic [CH_W-1:0]      win_ch;
  logic [DATA_W-1:0]    win_val;
  logic [DATA_W-1:0]    eff_val;
  logic [DATA_W-1:0]    ff_val;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 ch_end;
  logic                 wd_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      done_mask_q    <= '0;
      cnt_q          <= '0;
      exit_valid_q   <= 1'b0;
      exit_value_q   <= '0;
      exit_ch_q      <= '0;
      exit_timeout_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cap_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      done_mask_q    <= done_mask_d;
      cnt_q          <= cnt_d;
      exit_valid_q   <= exit_valid_d;
      exit_value_q   <= exit_value_d;
      exit_ch_q      <= exit_ch_d;
      exit_timeout_q <= exit_timeout_d;
      for (int i = 0; i < NUM_CH; i++) cap_q[i] <= cap_d[i];
    end
  end

  always_comb begin
    new_mask = '0;
    if (state_q == RUN) new_mask = ch_exit_valid_i & ~done_mask_q;
    mask_nxt = done_mask_q | new_mask;

    // Descending scans leave the lowest qualifying index as the final assignment.
    win_ch  = '0;
    win_val = '0;
    ff_val  = '0;
    eff_val = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (new_mask[i]) begin
        win_ch  = CH_W'(i);
        win_val = ch_exit_value_i[i*DATA_W +: DATA_W];
      end
      eff_val = new_mask[i] ? ch_exit_value_i[i*DATA_W +: DATA_W] : cap_q[i];
      if (eff_val != '0) ff_val = eff_val;
    end

    if (ALL_MODE != 0) ch_end = (new_mask != '0) && (&mask_nxt);
    else               ch_end = (new_mask != '0);

    cnt_inc = cnt_q + TIMEOUT_W'(1);
    wd_fire = (timeout_cycles_i != '0) && (cnt_inc == timeout_cycles_i);

    state_d        = state_q;
    done_mask_d    = done_mask_q;
    cnt_d          = cnt_q;
    cap_d          = cap_q;
    exit_valid_d   = exit_valid_q;
    exit_value_d   = exit_value_q;
    exit_ch_d      = exit_ch_q;
    exit_timeout_d = exit_timeout_q;

    if (clear_i) begin
      state_d        = RUN;
      done_mask_d    = '0;
      cnt_d          = '0;
      exit_valid_d   = 1'b0;
      exit_value_d   = '0;
      exit_ch_d      = '0;
      exit_timeout_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) cap_d[i] = '0;
    end else if (state_q == RUN) begin
      done_mask_d = mask_nxt;
      cnt_d       = cnt_inc;
      for (int i = 0; i < NUM_CH; i++)
        if (new_mask[i]) cap_d[i] = ch_exit_value_i[i*DATA_W +: DATA_W];
      // Channel completion takes priority over a watchdog expiring in the same cycle.
      if (ch_end) begin
        state_d        = DONE;
        exit_valid_d   = 1'b1;
        exit_value_d   = (ALL_MODE != 0) ? ff_val : win_val;
        exit_ch_d      = win_ch;
        exit_timeout_d = 1'b0;
      end else if (wd_fire) begin
        state_d        = DONE;
        exit_valid_d   = 1'b1;
        exit_value_d   = TIMEOUT_CODE;
        exit_ch_d      = '0;
        exit_timeout_d = 1'b1;
      end
    end
  end

  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;
  assign exit_ch_o      = exit_ch_q;
  assign exit_timeout_o = exit_timeout_q;
  assign done_mask_o    = done_mask_q;

endmodule

// File: tb/tb_x_alp_exit_ctrl.sv
// Scoreboard bench for x_alp_exit_ctrl: one first-exit and one all-exit instance
// share stimulus; expected exit events are queued per instance and checked on rise.
module tb_x_alp_exit_ctrl;
  localparam int NCH = 4;
  localparam int DW  = 32;

  typedef struct {
    int          edge_n;
    logic [31:0] val;
    logic [1:0]  ch;
    logic        to;
    logic [3:0]  mask;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH-1:0]    valid = '0;
  logic [NCH*DW-1:0] value = '0;
  logic [31:0]       tmo = '0;
  logic              clear = 1'b0;

  logic              v0, v1, to0, to1;
  logic [DW-1:0]     val0, val1;
  logic [1:0]        ch0, ch1;
  logic [NCH-1:0]    m0, m1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic pv0 = 1'b0, pv1 = 1'b0;

  x_alp_exit_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .ALL_MODE(0), .TIMEOUT_W(32)) u_first (
    .clk_i(clk), .rst_i(rst), .ch_exit_valid_i(valid), .ch_exit_value_i(value),
    .timeout_cycles_i(tmo), .clear_i(clear), .exit_valid_o(v0), .exit_value_o(val0),
    .exit_ch_o(ch0), .exit_timeout_o(to0), .done_mask_o(m0));

  x_alp_exit_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .ALL_MODE(1), .TIMEOUT_W(32)) u_all (
    .clk_i(clk), .rst_i(rst), .ch_exit_valid_i(valid), .ch_exit_value_i(value),
    .timeout_cycles_i(tmo), .clear_i(clear), .exit_valid_o(v1), .exit_value_o(val1),
    .exit_ch_o(ch1), .exit_timeout_o(to1), .done_mask_o(m1));

  always #5 clk = ~clk;

  // Edges since reset release or since the clear_i edge.
  always @(posedge clk or posedge rst) begin
    if (rst)        cyc <= 0;
    else if (clear) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] vals(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic at_edge(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  task automatic pulse(input logic [NCH-1:0] m, input logic [NCH*DW-1:0] v);
    valid = m;
    value = v;
    @(negedge clk);
    valid = '0;
    value = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv0 = 1'b0;
      pv1 = 1'b0;
    end else begin
      if (v0 && !pv0) begin
        if (q0.size() == 0) check("first_unexpected_exit", 1, 0);
        else begin
          e = q0.pop_front();
          check("first_edge", 64'(cyc), 64'(e.edge_n));
          check("first_value", val0, e.val);
          check("first_ch", ch0, e.ch);
          check("first_timeout", to0, e.to);
          check("first_mask", m0, e.mask);
        end
      end
      if (v1 && !pv1) begin
        if (q1.size() == 0) check("all_unexpected_exit", 1, 0);
        else begin
          e = q1.pop_front();
          check("all_edge", 64'(cyc), 64'(e.edge_n));
          check("all_value", val1, e.val);
          check("all_ch", ch1, e.ch);
          check("all_timeout", to1, e.to);
          check("all_mask", m1, e.mask);
        end
      end
      pv0 = v0;
      pv1 = v1;
    end
  end

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {v1, v0}, 2'b00);
    check("rst_value0", val0, 0);
    check("rst_value1", val1, 0);
    check("rst_ch", {ch1, ch0}, 0);
    check("rst_timeout", {to1, to0}, 2'b00);
    check("rst_mask", {m1, m0}, 0);
    rst = 1'b0;

    // first exit on ch2, later ch0 strobe ignored by the first-exit instance
    q0.push_back('{10, 32'h5, 2'd2, 1'b0, 4'b0100});
    at_edge(10); pulse(4'b0100, vals(0, 0, 32'h5, 0));
    at_edge(13); pulse(4'b0001, vals(32'h99, 0, 0, 0));
    at_edge(16);
    check("s1_first_mask_frozen", m0, 4'b0100);
    check("s1_first_value_hold", val0, 32'h5);
    check("s1_all_mask", m1, 4'b0101);
    check("s1_all_no_exit", v1, 0);
    do_clear();

    // simultaneous ch1/ch3
    q0.push_back('{3, 32'h11, 2'd1, 1'b0, 4'b1010});
    at_edge(3); pulse(4'b1010, vals(0, 32'h11, 0, 32'h33));
    at_edge(6);
    check("s2_all_mask", m1, 4'b1010);
    check("s2_all_no_exit", v1, 0);
    do_clear();

    // all-exit with first-failure value, repeat strobe on ch2 ignored
    q0.push_back('{5, 32'h0, 2'd0, 1'b0, 4'b0001});
    q1.push_back('{20, 32'h7, 2'd3, 1'b0, 4'b1111});
    at_edge(5);  pulse(4'b0001, vals(0, 0, 0, 0));
    at_edge(8);  pulse(4'b0010, vals(0, 0, 0, 0));
    at_edge(9);  pulse(4'b0100, vals(0, 0, 32'h7, 0));
    at_edge(12); pulse(4'b0100, vals(0, 0, 32'h9, 0));
    at_edge(20); pulse(4'b1000, vals(0, 0, 0, 0));
    at_edge(23);
    check("s3_all_value_hold", val1, 32'h7);

    // watchdog limit 16
    tmo = 32'd16;
    do_clear();
    q0.push_back('{16, 32'hFFFF_FFFF, 2'd0, 1'b1, 4'b0000});
    q1.push_back('{16, 32'hFFFF_FFFF, 2'd0, 1'b1, 4'b0000});
    at_edge(21);
    check("s4_first_valid_hold", v0, 1);
    check("s4_all_timeout_hold", to1, 1);

    // watchdog disabled
    tmo = 32'd0;
    do_clear();
    repeat (1000) @(negedge clk);
    check("s4_no_exit_disabled", {v1, v0}, 2'b00);

    // channel completion beats watchdog in the same cycle
    tmo = 32'd8;
    do_clear();
    q0.push_back('{8, 32'h1, 2'd0, 1'b0, 4'b0001});
    q1.push_back('{8, 32'hFFFF_FFFF, 2'd0, 1'b1, 4'b0001});
    at_edge(8); pulse(4'b0001, vals(32'h1, 0, 0, 0));
    at_edge(11);

    // clear in DONE with a coincident strobe that must be discarded
    tmo = 32'd0;
    clear = 1'b1;
    valid = 4'b0010;
    value = vals(0, 32'h5, 0, 0);
    @(negedge clk);
    clear = 1'b0;
    valid = '0;
    value = '0;
    check("s6_clear_valid", {v1, v0}, 2'b00);
    check("s6_clear_value", {val1, val0}, 0);
    check("s6_clear_ch_to", {ch1, ch0, to1, to0}, 0);
    check("s6_clear_mask", {m1, m0}, 0);
    q0.push_back('{1, 32'h4, 2'd1, 1'b0, 4'b0010});
    pulse(4'b0010, vals(0, 32'h4, 0, 0));
    at_edge(4);
    check("s6_all_mask", m1, 4'b0010);

    // asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    check("s7_rst_valid", {v1, v0}, 2'b00);
    check("s7_rst_value", val0, 0);
    check("s7_rst_mask", {m1, m0}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("q_first_drained", 64'(q0.size()), 0);
    check("q_all_drained", 64'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
